// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between an instruction-fetch requester and a data
// load/store requester. One transaction is in flight at a time: a grant in
// IDLE latches the command, BUSY drives it until mem_ack or a wait-cycle
// timeout, and RESP returns a single rvalid pulse to whichever side owned it.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,

    output logic        err,
    output logic        stall
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic OWNER_FETCH = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;

    // TIMEOUT is at most 1023, so ten bits always hold the wait count.
    localparam int unsigned CNT_W = 10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q,      state_d;
    logic             owner_q,      owner_d;
    logic             last_owner_q, last_owner_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             mem_req_q,    mem_req_d;
    logic             mem_we_q,     mem_we_d;
    logic [3:0]       mem_be_q,     mem_be_d;
    logic [31:0]      mem_addr_q,   mem_addr_d;
    logic [31:0]      mem_wdata_q,  mem_wdata_d;
    logic [31:0]      rdata_q,      rdata_d;
    logic             err_q,        err_d;
    logic             if_rvalid_q,  if_rvalid_d;
    logic             d_rvalid_q,   d_rvalid_d;

    // Grants exist only in IDLE; on a tie the side that did not win last time goes.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (state_q == ST_IDLE && !reset) begin
            if (if_req && d_req) begin
                if (last_owner_q == OWNER_DATA) begin
                    if_gnt = 1'b1;
                end else begin
                    d_gnt = 1'b1;
                end
            end else if (if_req) begin
                if_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    // Next-state and next-output computation for the IDLE/BUSY/RESP sequence.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        mem_be_d     = 4'h0;
        mem_addr_d   = 32'h0;
        mem_wdata_d  = 32'h0;
        err_d        = 1'b0;
        if_rvalid_d  = 1'b0;
        d_rvalid_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (if_gnt) begin
                    state_d      = ST_BUSY;
                    owner_d      = OWNER_FETCH;
                    last_owner_d = OWNER_FETCH;
                    cnt_d        = '0;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_be_d     = 4'hF;
                    mem_addr_d   = if_addr;
                    mem_wdata_d  = 32'h0;
                end else if (d_gnt) begin
                    state_d      = ST_BUSY;
                    owner_d      = OWNER_DATA;
                    last_owner_d = OWNER_DATA;
                    cnt_d        = '0;
                    mem_req_d    = 1'b1;
                    mem_we_d     = d_we;
                    mem_be_d     = d_be;
                    mem_addr_d   = d_addr;
                    mem_wdata_d  = d_wdata;
                end
            end

            ST_BUSY: begin
                if (mem_ack) begin
                    state_d     = ST_RESP;
                    rdata_d     = mem_we_q ? 32'h0 : mem_rdata;
                    err_d       = 1'b0;
                    if_rvalid_d = (owner_q == OWNER_FETCH);
                    d_rvalid_d  = (owner_q == OWNER_DATA);
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_RESP;
                    rdata_d     = 32'h0;
                    err_d       = 1'b1;
                    if_rvalid_d = (owner_q == OWNER_FETCH);
                    d_rvalid_d  = (owner_q == OWNER_DATA);
                end else begin
                    cnt_d       = cnt_q + 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = mem_we_q;
                    mem_be_d    = mem_be_q;
                    mem_addr_d  = mem_addr_q;
                    mem_wdata_d = mem_wdata_q;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Register all state and registered outputs; reset leaves data as last owner.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWNER_FETCH;
            last_owner_q <= OWNER_DATA;
            cnt_q        <= '0;
            rdata_q      <= 32'h0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'h0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            err_q        <= 1'b0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            err_q        <= err_d;
            if_rvalid_q  <= if_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
        end
    end

    // Datapath must hold while a transaction is in flight or a request waits.
    always_comb begin
        stall = (state_q != ST_IDLE) || (if_req && !if_gnt) || (d_req && !d_gnt);
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = rdata_q;
    assign d_rdata   = rdata_q;
    assign err       = err_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles BUSY waits for mem_ack before abort (range 1..1023).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 if_req  input  1  instruction-fetch request; held until if_gnt.
REQ-005 if_addr  input  32  fetch address (pc).
REQ-006 if_gnt  output  1  fetch request accepted this cycle.
REQ-007 if_rvalid  output  1  one-cycle pulse: if_rdata/err valid.
REQ-008 if_rdata  output  32  fetched instruction word.
REQ-009 d_req  input  1  data load/store request; held until d_gnt.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_be  input  4  store byte enables.
REQ-012 d_addr  input  32  data address (ALU result).
REQ-013 d_wdata  input  32  store data (rs2).
REQ-014 d_gnt  output  1  data request accepted this cycle.
REQ-015 d_rvalid  output  1  one-cycle pulse: d_rdata/err valid (loads and stores).
REQ-016 d_rdata  output  32  raw load data, before load extension.
REQ-017 mem_req  output  1  shared memory port request.
REQ-018 mem_we, mem_be[3:0], mem_addr[31:0], mem_wdata[31:0]  outputs  shared port command.
REQ-019 mem_ack  input  1  memory completion pulse; mem_rdata valid in the same cycle.
REQ-020 mem_rdata  input  32  memory read data.
REQ-021 err  output  1  timeout flag, valid alongside the rvalid pulse.
REQ-022 stall  output  1  datapath hold: asserted whenever state != IDLE or an ungranted request is present.

Function
REQ-023 FSM states IDLE, BUSY, RESP; at most one transaction outstanding.
REQ-024 IDLE: if_gnt/d_gnt are combinational from the req inputs; at most one is high; no grant outside IDLE.
REQ-025 Arbitration when both requests are high: round-robin via a last_owner register; the requester that did not win last time wins; a single requester always wins.
REQ-026 On grant: latch owner and command (fetch: mem_we=0, mem_be=4'hF, mem_wdata=0); go to BUSY; update last_owner.
REQ-027 BUSY: mem_req=1 with latched command held stable every cycle until mem_ack or timeout.
REQ-028 BUSY with mem_ack: capture mem_rdata (0 for stores), err=0, go to RESP.
REQ-029 BUSY wait counter starts at 0 on BUSY entry and increments each cycle without mem_ack; reaching TIMEOUT aborts: rdata=0, err=1, go to RESP, mem_req drops.
REQ-030 RESP: the owner's rvalid=1 for exactly one cycle with captured data and err; then IDLE; mem_req=0.
REQ-031 Latency: grant at cycle T, mem_req at T+1..T+k (ack at T+k), rvalid at T+k+1, earliest next grant at T+k+2.
REQ-032 The non-owner rvalid stays 0; rdata outputs hold the last captured value between pulses.
REQ-033 mem_ack in IDLE or RESP is ignored, with no state or output change.
REQ-034 A request deasserted before grant is dropped without side effects.

Reset
REQ-035 Reset forces IDLE, last_owner=data (fetch wins first tie), counter=0, captured data=0, err=0.
REQ-036 During reset and the following cycle: mem_req, if_rvalid, d_rvalid, err = 0; mem command outputs = 0.
REQ-037 Reset mid-BUSY abandons the transaction with no rvalid pulse; a late mem_ack is ignored per REQ-033.

Verification
REQ-038 Fetch only: if_req, if_addr=0x80000000, ack 3 cycles after mem_req with rdata 0x00000013 -> if_gnt at T, mem_addr=0x80000000 for 3 cycles, if_rvalid at T+4 with 0x00000013, err=0.
REQ-039 Tie: both requests high from reset release -> fetch granted first; data granted in the first IDLE after fetch rvalid; third tie goes to fetch.
REQ-040 Store: d_we=1, d_be=4'b0011, d_addr=0x80001000, d_wdata=0xDEADBEEF, ack immediate -> mem_* match for 1 cycle; d_rvalid with d_rdata=0, err=0.
REQ-041 Timeout: TIMEOUT=4, no ack -> mem_req high exactly 4 cycles, then rvalid with err=1, rdata=0, then IDLE.
REQ-042 Reset asserted in BUSY with ack on the next cycle -> no rvalid, mem_req=0, state IDLE, stall=0 with no requests.
